// File: rtl/fifo_drain.sv
// Two-entry registered output stage (head + skid) between a synchronous fifo and a valid/ready consumer.
// Define FIFO_DRAIN_CHECK_EN to compile in simulation-only protocol checks; synthesised logic is unchanged.
module fifo_drain #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] fifo_out,
  input  logic         fifo_empty,
  output logic         fifo_pop,
  input  logic         flush,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       r_count;
  state_t       count_next;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [W-1:0] slot0_next;
  logic [W-1:0] slot1_next;
  logic         take;

  // Pop looks only at registered state and upstream/flush, so out_ready never reaches the FIFO.
  assign fifo_pop  = reset & ~fifo_empty & ~flush & (r_count != TWO);
  assign out_valid = (r_count != EMPTY);
  assign out_data  = slot0;
  assign occupancy = r_count;
  assign take      = out_valid & out_ready;

  always_comb begin
    count_next = r_count;
    slot0_next = slot0;
    slot1_next = slot1;
    if (flush) begin
      count_next = EMPTY;
    end else begin
      case (r_count)
        EMPTY: begin
          if (fifo_pop) begin
            slot0_next = fifo_out;
            count_next = ONE;
          end
        end
        ONE: begin
          if (fifo_pop && take) begin
            slot0_next = fifo_out;
          end else if (fifo_pop) begin
            slot1_next = fifo_out;
            count_next = TWO;
          end else if (take) begin
            count_next = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            slot0_next = slot1;
            count_next = ONE;
          end
        end
        default: count_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= EMPTY;
    end else begin
      r_count <= count_next;
    end
  end

  // Slot contents are only meaningful alongside r_count, so they carry no reset.
  always_ff @(posedge clk) begin
    slot0 <= slot0_next;
    slot1 <= slot1_next;
  end

`ifdef FIFO_DRAIN_CHECK_EN
  logic         chk_valid;
  logic         chk_take;
  logic         chk_flush;
  logic         chk_hold;
  logic [W-1:0] chk_data;

  always @(negedge clk) begin
    if (reset) begin
      if (chk_valid && !out_valid && !chk_take && !chk_flush) $stop;
      if (chk_hold && out_data != chk_data) $stop;
      if (fifo_pop && fifo_empty) $stop;
      if (r_count > TWO) $stop;
    end
    chk_valid <= out_valid & reset;
    chk_take  <= take;
    chk_flush <= flush;
    chk_hold  <= out_valid & ~out_ready & ~flush & reset;
    chk_data  <= out_data;
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: queue-based model of upstream fifo and drain contents,
// per-cycle compare at negedge plus directed literal expectations.
module tb_fifo_drain;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] fifo_out;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         flush;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  fifo_drain #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_out  (fifo_out),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: upstream fifo contents, entries held by the drain stage, and completed transfers.
  logic [W-1:0] up_q[$];
  logic [W-1:0] held[$];
  logic [W-1:0] accepted[$];

  logic         exp_pop;
  logic         exp_valid;
  logic [W-1:0] exp_data;
  logic [1:0]   exp_occ;
  logic         compare_on;

  int checks;
  int errors;

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput();
    compareVal("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    compareVal("out_valid", 32'(out_valid), 32'(exp_valid));
    compareVal("occupancy", 32'(occupancy), 32'(exp_occ));
    if (exp_valid) compareVal("out_data", out_data, exp_data);
  endtask

  always @(negedge clk) begin
    if (compare_on) checkOutput();
  end

  task automatic refreshFifo();
    fifo_empty = (up_q.size() == 0);
    fifo_out   = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  task automatic pushEntry(input logic [W-1:0] val);
    up_q.push_back(val);
    refreshFifo();
  endtask

  // Drive this cycle's inputs, derive expected outputs, then wait for the compare edge.
  task automatic applyStimulus(input logic ready, input logic fl);
    out_ready = ready;
    flush     = fl;
    refreshFifo();
    if (!reset) held.delete();
    exp_occ    = 2'(held.size());
    exp_valid  = (held.size() != 0);
    exp_data   = (held.size() != 0) ? held[0] : '0;
    exp_pop    = reset && (up_q.size() != 0) && !fl && (held.size() < 2);
    compare_on = 1'b1;
    @(negedge clk);
  endtask

  // Cross the active edge and move the model by the same rules the consumer/fifo see.
  task automatic advance();
    logic take;
    @(posedge clk);
    #1;
    if (!reset) begin
      held.delete();
    end else begin
      take = exp_valid && out_ready;
      if (take) accepted.push_back(held[0]);
      if (flush) begin
        held.delete();
      end else begin
        if (take) held.delete(0);
        if (exp_pop) held.push_back(up_q.pop_front());
      end
    end
    refreshFifo();
  endtask

  task automatic runCycles(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      applyStimulus(ready, 1'b0);
      advance();
    end
  endtask

  initial begin
    logic [W-1:0] abc[3];
    int           base;
    checks     = 0;
    errors     = 0;
    compare_on = 1'b0;
    reset      = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    refreshFifo();
    repeat (2) @(posedge clk);
    #1;

    // Reset held low with three entries waiting upstream.
    pushEntry(32'h101);
    pushEntry(32'h102);
    pushEntry(32'h103);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      compareVal("rst_pop", 32'(fifo_pop), 32'd0);
      compareVal("rst_valid", 32'(out_valid), 32'd0);
      compareVal("rst_occ", 32'(occupancy), 32'd0);
      advance();
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    compareVal("rel_pop", 32'(fifo_pop), 32'd1);
    compareVal("rel_valid", 32'(out_valid), 32'd0);
    advance();
    applyStimulus(1'b0, 1'b0);
    compareVal("rel_valid1", 32'(out_valid), 32'd1);
    compareVal("rel_data1", out_data, 32'h101);
    advance();
    runCycles(4, 1'b1);
    compareVal("rel_count", 32'(accepted.size()), 32'd3);
    compareVal("rel_acc0", accepted[0], 32'h101);
    compareVal("rel_acc2", accepted[2], 32'h103);

    // Full-throughput stream 0x11..0x18.
    for (int k = 0; k < 8; k++) pushEntry(32'h11 + 32'(k));
    applyStimulus(1'b1, 1'b0);
    compareVal("thr_pop0", 32'(fifo_pop), 32'd1);
    compareVal("thr_valid0", 32'(out_valid), 32'd0);
    advance();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0);
      compareVal("thr_valid", 32'(out_valid), 32'd1);
      compareVal("thr_data", out_data, 32'h11 + 32'(k));
      compareVal("thr_occ", 32'(occupancy), 32'd1);
      advance();
    end
    applyStimulus(1'b1, 1'b0);
    compareVal("thr_end_valid", 32'(out_valid), 32'd0);
    advance();

    // Backpressure: only two pops, third entry stays upstream.
    base   = accepted.size();
    abc[0] = 32'hA;
    abc[1] = 32'hB;
    abc[2] = 32'hC;
    for (int k = 0; k < 3; k++) pushEntry(abc[k]);
    runCycles(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0);
      compareVal("bp_occ", 32'(occupancy), 32'd2);
      compareVal("bp_data", out_data, 32'hA);
      compareVal("bp_pop", 32'(fifo_pop), 32'd0);
      compareVal("bp_upsize", 32'(up_q.size()), 32'd1);
      compareVal("bp_uphead", up_q[0], 32'hC);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      compareVal("bp_drain", out_data, abc[k]);
      advance();
    end
    compareVal("bp_acc0", accepted[base], 32'hA);
    compareVal("bp_acc1", accepted[base+1], 32'hB);
    compareVal("bp_acc2", accepted[base+2], 32'hC);

    // Flush at occupancy 2 with a concurrent take, then flush at occupancy 1 with data upstream.
    pushEntry(32'h1);
    pushEntry(32'h2);
    pushEntry(32'h3);
    runCycles(2, 1'b0);
    applyStimulus(1'b1, 1'b1);
    compareVal("fl_occ", 32'(occupancy), 32'd2);
    compareVal("fl_data", out_data, 32'h1);
    compareVal("fl_pop", 32'(fifo_pop), 32'd0);
    advance();
    applyStimulus(1'b0, 1'b0);
    compareVal("fl_valid_next", 32'(out_valid), 32'd0);
    compareVal("fl_refill_pop", 32'(fifo_pop), 32'd1);
    advance();
    pushEntry(32'h4);
    applyStimulus(1'b0, 1'b1);
    compareVal("fl1_data", out_data, 32'h3);
    compareVal("fl1_pop", 32'(fifo_pop), 32'd0);
    advance();
    applyStimulus(1'b0, 1'b0);
    compareVal("fl1_valid_next", 32'(out_valid), 32'd0);
    advance();
    applyStimulus(1'b1, 1'b0);
    compareVal("fl1_refill", out_data, 32'h4);
    advance();
    compareVal("fl_acc_a", accepted[accepted.size()-2], 32'h1);
    compareVal("fl_acc_b", accepted[accepted.size()-1], 32'h4);

    // Asynchronous reset while holding two entries.
    pushEntry(32'h5);
    pushEntry(32'h6);
    pushEntry(32'h7);
    runCycles(2, 1'b0);
    reset = 1'b0;
    up_q.delete();
    held.delete();
    refreshFifo();
    #1;
    compareVal("async_valid", 32'(out_valid), 32'd0);
    compareVal("async_occ", 32'(occupancy), 32'd0);
    runCycles(2, 1'b1);
    reset = 1'b1;

    // Random push / ready / flush traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      if (up_q.size() < 6 && $urandom_range(1, 0) == 1) pushEntry($urandom);
      applyStimulus($urandom_range(9, 0) < 6, $urandom_range(49, 0) == 0);
      advance();
    end
    runCycles(8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
